// File: rtl/ped_crossing_unit.sv
// Pedestrian endpoint of the traffic-light controller: debounces the crosswalk button,
// holds the request until acknowledged, drives the lamps/countdown and flags controller faults.
module ped_crossing_unit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FLASH_TICKS     = 6,
    parameter int MAX_WAIT_CYCLES = 2
) (
    input  logic                               clk,
    input  logic                               resetN,
    input  logic                               tick,
    input  logic                               buttonRaw,
    input  logic                               pedOn,
    input  logic                               pedLight,
    input  logic                               newCycle,
    input  logic                               SG,
    output logic                               pedButton,
    output logic                               waitLamp,
    output logic                               walkLamp,
    output logic                               dontWalkLamp,
    output logic [$clog2(FLASH_TICKS+1)-1:0]   countdown,
    output logic                               fault
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int CD_W = $clog2(FLASH_TICKS + 1);
    localparam int WC_W = $clog2(MAX_WAIT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, REQUEST, ACCEPTED, WALK, CLEAR} state_t;

    logic            sync1_q, sync2_q;
    logic            deb_q, deb_d, deb_prev_q;
    logic [DB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic            new_cycle_prev_q;
    logic            press_evt, nc_rise;

    state_t          state_q, state_d;
    logic            pending_q, pending_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CD_W-1:0] countdown_q, countdown_d;
    logic            ped_button_q, ped_button_d;
    logic            wait_lamp_q, wait_lamp_d;
    logic            walk_lamp_q, walk_lamp_d;
    logic            dont_walk_q, dont_walk_d;
    logic            fault_q, fault_d;

    // NOTE: every flop is written with <= so all registers sample pre-edge values together.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync1_q          <= 1'b0;
            sync2_q          <= 1'b0;
            deb_q            <= 1'b0;
            deb_prev_q       <= 1'b0;
            deb_cnt_q        <= '0;
            new_cycle_prev_q <= 1'b0;
        end else begin
            sync1_q          <= buttonRaw;
            sync2_q          <= sync1_q;
            deb_q            <= deb_d;
            deb_prev_q       <= deb_q;
            deb_cnt_q        <= deb_cnt_d;
            new_cycle_prev_q <= newCycle;
        end
    end

    // NOTE: defaults first so no path through always_comb leaves a signal unassigned (no latches).
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) deb_d = sync2_q;
            else                                         deb_cnt_d = deb_cnt_q + DB_W'(1);
        end
    end

    assign press_evt = deb_q & ~deb_prev_q;
    assign nc_rise   = newCycle & ~new_cycle_prev_q;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        wait_cnt_d  = wait_cnt_q;
        countdown_d = countdown_q;
        dont_walk_d = dont_walk_q;
        fault_d     = fault_q;

        case (state_q)
            IDLE:     if (press_evt) state_d = REQUEST;
            REQUEST: begin
                if (pedLight)   state_d = WALK;
                else if (pedOn) state_d = ACCEPTED;
            end
            ACCEPTED: if (pedLight) state_d = WALK;
            WALK: begin
                if (!pedLight) begin
                    state_d     = CLEAR;
                    countdown_d = CD_W'(FLASH_TICKS);
                    dont_walk_d = 1'b1;
                end
            end
            CLEAR: begin
                if (press_evt) pending_d = 1'b1;
                if (tick) begin
                    if (countdown_q == CD_W'(1)) begin
                        countdown_d = '0;
                        dont_walk_d = 1'b1;
                        state_d     = (pending_q || press_evt) ? REQUEST : IDLE;
                        pending_d   = 1'b0;
                    end else begin
                        countdown_d = countdown_q - CD_W'(1);
                        dont_walk_d = ~dont_walk_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Starvation watch saturates at the limit; the request keeps waiting afterwards.
        if ((state_q == REQUEST || state_q == ACCEPTED) && nc_rise &&
            wait_cnt_q != WC_W'(MAX_WAIT_CYCLES)) begin
            wait_cnt_d = wait_cnt_q + WC_W'(1);
            if (wait_cnt_q == WC_W'(MAX_WAIT_CYCLES - 1)) fault_d = 1'b1;
        end
        if (state_d == REQUEST && state_q != REQUEST) wait_cnt_d = '0;

        if (pedLight && (state_q == IDLE || SG)) fault_d = 1'b1;

        if (state_d == WALK)       dont_walk_d = 1'b0;
        else if (state_d != CLEAR) dont_walk_d = 1'b1;

        ped_button_d = (state_d == REQUEST);
        wait_lamp_d  = (state_d == REQUEST) || (state_d == ACCEPTED);
        walk_lamp_d  = (state_d == WALK);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            pending_q    <= 1'b0;
            wait_cnt_q   <= '0;
            countdown_q  <= '0;
            ped_button_q <= 1'b0;
            wait_lamp_q  <= 1'b0;
            walk_lamp_q  <= 1'b0;
            dont_walk_q  <= 1'b1;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            wait_cnt_q   <= wait_cnt_d;
            countdown_q  <= countdown_d;
            ped_button_q <= ped_button_d;
            wait_lamp_q  <= wait_lamp_d;
            walk_lamp_q  <= walk_lamp_d;
            dont_walk_q  <= dont_walk_d;
            fault_q      <= fault_d;
        end
    end

    assign pedButton    = ped_button_q;
    assign waitLamp     = wait_lamp_q;
    assign walkLamp     = walk_lamp_q;
    assign dontWalkLamp = dont_walk_q;
    assign countdown    = countdown_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_ped_crossing_unit.sv
// Directed self-checking bench for ped_crossing_unit (DEBOUNCE_CYCLES=4, FLASH_TICKS=6, MAX_WAIT_CYCLES=2).
module tb_ped_crossing_unit;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       tick = 1'b0;
    logic       buttonRaw = 1'b0;
    logic       pedOn = 1'b0;
    logic       pedLight = 1'b0;
    logic       newCycle = 1'b0;
    logic       SG = 1'b0;
    logic       pedButton, waitLamp, walkLamp, dontWalkLamp, fault;
    logic [2:0] countdown;

    int n_checks = 0;
    int n_errors = 0;

    ped_crossing_unit #(
        .DEBOUNCE_CYCLES(4),
        .FLASH_TICKS(6),
        .MAX_WAIT_CYCLES(2)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .tick(tick),
        .buttonRaw(buttonRaw),
        .pedOn(pedOn),
        .pedLight(pedLight),
        .newCycle(newCycle),
        .SG(SG),
        .pedButton(pedButton),
        .waitLamp(waitLamp),
        .walkLamp(walkLamp),
        .dontWalkLamp(dontWalkLamp),
        .countdown(countdown),
        .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(2);
    endtask

    // From REQUEST: acknowledge, walk for 4 cycles, end in CLEAR with countdown=6.
    task automatic accept_and_walk();
        pedOn = 1'b1;
        step(1);
        pedOn = 1'b0;
        pedLight = 1'b1;
        step(4);
        pedLight = 1'b0;
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        step(3);
        check("rst_pedButton", pedButton, 0);
        check("rst_waitLamp", waitLamp, 0);
        check("rst_walkLamp", walkLamp, 0);
        check("rst_dontWalk", dontWalkLamp, 1);
        check("rst_countdown", countdown, 0);
        check("rst_fault", fault, 0);
        resetN = 1'b1;
        step(2);

        // Press and service: pedButton rises on edge 7 after the press
        buttonRaw = 1'b1;
        step(6);
        check("press_lat6_pedButton", pedButton, 0);
        step(1);
        check("press_lat7_pedButton", pedButton, 1);
        check("press_waitLamp", waitLamp, 1);
        check("press_dontWalk", dontWalkLamp, 1);
        for (int i = 0; i < 3; i++) tick_pulse();
        check("held_over_ticks", pedButton, 1);
        pedOn = 1'b1;
        step(1);
        pedOn = 1'b0;
        buttonRaw = 1'b0;
        check("accepted_pedButton", pedButton, 0);
        check("accepted_waitLamp", waitLamp, 1);

        // Full crossing
        pedLight = 1'b1;
        step(1);
        check("walk_walkLamp", walkLamp, 1);
        check("walk_dontWalk", dontWalkLamp, 0);
        check("walk_waitLamp", waitLamp, 0);
        step(4);
        check("walk_hold", walkLamp, 1);
        pedLight = 1'b0;
        step(1);
        check("clear_walkLamp", walkLamp, 0);
        check("clear_countdown_load", countdown, 6);
        check("clear_dontWalk_entry", dontWalkLamp, 1);
        for (int i = 5; i >= 0; i--) begin
            tick = 1'b1;
            step(1);
            tick = 1'b0;
            check($sformatf("clear_cd_%0d", i), countdown, i);
            check($sformatf("clear_dw_%0d", i), dontWalkLamp, (i % 2 == 0) ? 1 : 0);
            step(2);
        end
        check("idle_pedButton", pedButton, 0);
        check("idle_waitLamp", waitLamp, 0);
        check("idle_dontWalk", dontWalkLamp, 1);
        check("idle_fault", fault, 0);

        // Bounce rejection, then one event from a long hold
        for (int i = 0; i < 3; i++) begin
            buttonRaw = 1'b1;
            step(3);
            buttonRaw = 1'b0;
            step(2);
        end
        step(8);
        check("bounce_no_request", pedButton, 0);
        check("bounce_no_wait", waitLamp, 0);
        buttonRaw = 1'b1;
        step(6);
        check("hold_lat6", pedButton, 0);
        step(1);
        check("hold_lat7", pedButton, 1);
        accept_and_walk();
        for (int i = 0; i < 6; i++) tick_pulse();
        check("hold_single_event_pedButton", pedButton, 0);
        check("hold_single_event_waitLamp", waitLamp, 0);
        buttonRaw = 1'b0;
        step(8);

        // Press during CLEAR
        buttonRaw = 1'b1;
        step(7);
        buttonRaw = 1'b0;
        step(8);
        accept_and_walk();
        for (int i = 0; i < 3; i++) tick_pulse();
        check("pc_countdown3", countdown, 3);
        buttonRaw = 1'b1;
        step(10);
        buttonRaw = 1'b0;
        step(8);
        tick_pulse();
        tick_pulse();
        check("pc_countdown1", countdown, 1);
        check("pc_still_clear", pedButton, 0);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        check("pc_countdown0", countdown, 0);
        check("pc_request_pedButton", pedButton, 1);
        check("pc_request_waitLamp", waitLamp, 1);
        check("pc_dontWalk", dontWalkLamp, 1);

        // Starvation: fault on the second newCycle rise, request still held
        newCycle = 1'b1;
        step(1);
        check("starve_first_edge", fault, 0);
        newCycle = 1'b0;
        step(2);
        newCycle = 1'b1;
        step(1);
        check("starve_second_edge", fault, 1);
        check("starve_pedButton", pedButton, 1);
        newCycle = 1'b0;
        resetN = 1'b0;
        #2;
        check("async_rst_fault", fault, 0);
        check("async_rst_pedButton", pedButton, 0);
        check("async_rst_waitLamp", waitLamp, 0);
        step(2);
        resetN = 1'b1;
        step(1);

        // Unrequested walk in IDLE
        pedLight = 1'b1;
        step(1);
        check("unreq_fault", fault, 1);
        check("unreq_walkLamp", walkLamp, 0);
        check("unreq_dontWalk", dontWalkLamp, 1);
        pedLight = 1'b0;
        step(3);
        check("unreq_sticky", fault, 1);
        check("unreq_idle", pedButton, 0);
        resetN = 1'b0;
        step(1);
        check("reset_clears_fault", fault, 0);
        resetN = 1'b1;
        step(1);

        // Walk during side-street green, then asynchronous reset mid-WALK
        buttonRaw = 1'b1;
        step(7);
        buttonRaw = 1'b0;
        pedOn = 1'b1;
        step(1);
        pedOn = 1'b0;
        pedLight = 1'b1;
        step(1);
        check("sg_walk_entry", walkLamp, 1);
        check("sg_no_fault_yet", fault, 0);
        SG = 1'b1;
        step(1);
        SG = 1'b0;
        check("sg_fault", fault, 1);
        check("sg_still_walk", walkLamp, 1);
        step(2);
        resetN = 1'b0;
        #2;
        check("midwalk_rst_walkLamp", walkLamp, 0);
        check("midwalk_rst_dontWalk", dontWalkLamp, 1);
        check("midwalk_rst_countdown", countdown, 0);
        check("midwalk_rst_fault", fault, 0);
        check("midwalk_rst_pedButton", pedButton, 0);
        check("midwalk_rst_waitLamp", waitLamp, 0);
        pedLight = 1'b0;
        step(2);
        resetN = 1'b1;
        step(2);
        check("post_rst_walkLamp", walkLamp, 0);
        check("post_rst_dontWalk", dontWalkLamp, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
